// File: rtl/simd_fetch_decode.sv
// simd_fetch_decode
// Sequential fetch/decode front end for a small SIMD engine. On a start
// request it walks instruction memory from address 0. It skips NOPs and
// offers every other legal instruction downstream through a valid/ready
// handshake. It ends the program on STOP (after issuing it) or on an illegal
// opcode.
//
// Optional feature: define SIMD_FD_PERF_COUNT_EN to add the issue_count
// output, a saturating count of completed issue handshakes.
//
// Opcode map (upper four instruction bits):
//   0x0 NOP, 0x1 FETCH_A, 0x2 FETCH_B, 0x3 ADD, 0x4 STOP, 0x5 SUB,
//   0x6 MUL, 0x7 STORE; 0x8-0xF are illegal (top opcode bit set).
module simd_fetch_decode #(
    parameter int INST_LEN   = 12,
    parameter int PC_LEN     = 12,
    parameter int DRAM_DEPTH = 256,
    localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       valid,
    output logic [PC_LEN-1:0]          inst_read_addr,
    input  logic [INST_LEN-1:0]        inst_read_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [3:0]                 issue_op,
    output logic [DRAM_ADDR_WIDTH-1:0] issue_addr,
    output logic                       busy,
    output logic                       stop,
    output logic                       illegal
`ifdef SIMD_FD_PERF_COUNT_EN
    ,
    output logic [PC_LEN-1:0]          issue_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STOP = 4'h4;

    state_t                     state_q;
    logic [PC_LEN-1:0]          pc_q;
    logic [3:0]                 issueOp_q;
    logic [DRAM_ADDR_WIDTH-1:0] issueAddr_q;
    logic                       issueValid_q;
    logic                       busy_q;
    logic                       stop_q;
    logic                       illegal_q;

    logic [3:0]                 latchOp;
    logic [DRAM_ADDR_WIDTH-1:0] latchAddr;
    logic [PC_LEN-1:0]          pcInc;
    logic                       startAccept;
    logic                       handshake;

    // The instruction word arriving from memory, split into opcode and operand
    // address. A start request is accepted only while idle or finished. A
    // handshake happens only while an instruction is on offer.
    assign latchOp     = inst_read_data[INST_LEN-1 -: 4];
    assign latchAddr   = inst_read_data[DRAM_ADDR_WIDTH-1:0];
    assign pcInc       = pc_q + PC_LEN'(1);
    assign startAccept = valid && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign handshake   = (state_q == S_ISSUE) && issue_ready;

    // Main sequencer. The pc doubles as the instruction address, so the
    // memory address is already stable throughout FETCH. Every output is a
    // register that is updated together with the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            issueOp_q    <= '0;
            issueAddr_q  <= '0;
            issueValid_q <= 1'b0;
            busy_q       <= 1'b0;
            stop_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (startAccept) begin
                        state_q   <= S_FETCH;
                        pc_q      <= '0;
                        busy_q    <= 1'b1;
                        stop_q    <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    issueOp_q   <= latchOp;
                    issueAddr_q <= latchAddr;
                    if (latchOp == OP_NOP) begin
                        state_q <= S_FETCH;
                        pc_q    <= pcInc;
                    end else if (latchOp[3]) begin
                        state_q   <= S_DONE;
                        illegal_q <= 1'b1;
                        stop_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q      <= S_ISSUE;
                        issueValid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issueValid_q <= 1'b0;
                        if (issueOp_q == OP_STOP) begin
                            state_q <= S_DONE;
                            stop_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                            pc_q    <= pcInc;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    issueValid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIMD_FD_PERF_COUNT_EN
    logic [PC_LEN-1:0] issueCount_q;

    // Count completed handshakes per program run, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issueCount_q <= '0;
        end else if (startAccept) begin
            issueCount_q <= '0;
        end else if (handshake && (issueCount_q != '1)) begin
            issueCount_q <= issueCount_q + PC_LEN'(1);
        end
    end

    assign issue_count = issueCount_q;
`endif

    assign inst_read_addr = pc_q;
    assign issue_valid    = issueValid_q;
    assign issue_op       = issueOp_q;
    assign issue_addr     = issueAddr_q;
    assign busy           = busy_q;
    assign stop           = stop_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_simd_fetch_decode.sv
// tb_simd_fetch_decode
// Directed bench for simd_fetch_decode. It contains a one-cycle-latency
// instruction memory model and a handshake log. Define SIMD_FD_PERF_COUNT_EN
// to exercise the issue_count output as well.
module tb_simd_fetch_decode;

    localparam int INST_LEN   = 12;
    localparam int PC_LEN     = 12;
    localparam int DRAM_DEPTH = 256;
    localparam int AW         = $clog2(DRAM_DEPTH);
    localparam int MEM_WORDS  = 1 << PC_LEN;

    logic                clk = 1'b0;
    logic                rstn;
    logic                valid;
    logic [PC_LEN-1:0]   inst_read_addr;
    logic [INST_LEN-1:0] inst_read_data;
    logic                issue_valid;
    logic                issue_ready;
    logic [3:0]          issue_op;
    logic [AW-1:0]       issue_addr;
    logic                busy;
    logic                stop;
    logic                illegal;
`ifdef SIMD_FD_PERF_COUNT_EN
    logic [PC_LEN-1:0]   issue_count;
`endif

    logic [INST_LEN-1:0] mem [0:MEM_WORDS-1];
    logic [3:0]          opLog[$];
    logic [AW-1:0]       addrLog[$];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    simd_fetch_decode #(
        .INST_LEN   (INST_LEN),
        .PC_LEN     (PC_LEN),
        .DRAM_DEPTH (DRAM_DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .valid          (valid),
        .inst_read_addr (inst_read_addr),
        .inst_read_data (inst_read_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_op       (issue_op),
        .issue_addr     (issue_addr),
        .busy           (busy),
        .stop           (stop),
        .illegal        (illegal)
`ifdef SIMD_FD_PERF_COUNT_EN
        ,
        .issue_count    (issue_count)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Instruction memory: data follows the address by one cycle.
    always @(posedge clk) inst_read_data <= mem[inst_read_addr];

    // Record every completed handshake that reset does not override.
    always @(posedge clk) begin
        if (rstn === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            opLog.push_back(issue_op);
            addrLog.push_back(issue_addr);
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r);
        valid       = v;
        issue_ready = r;
    endtask

    task automatic pulseValid();
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic fillMem(input logic [INST_LEN-1:0] word);
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = word;
    endtask

    task automatic loadProgramA();
        fillMem(12'hF00);
        mem[0] = 12'h100;
        mem[1] = 12'h200;
        mem[2] = 12'h300;
        mem[3] = 12'h400;
    endtask

    task automatic waitIssue(input int maxCycles, output int n);
        n = 0;
        while (issue_valid !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitDone(input string tag, input int maxCycles);
        int n = 0;
        while (stop !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(stop), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_addr"},  32'(inst_read_addr), 32'd0);
        checkOutput({tag, "_ivld"},  32'(issue_valid),    32'd0);
        checkOutput({tag, "_op"},    32'(issue_op),       32'd0);
        checkOutput({tag, "_iaddr"}, 32'(issue_addr),     32'd0);
        checkOutput({tag, "_busy"},  32'(busy),           32'd0);
        checkOutput({tag, "_stop"},  32'(stop),           32'd0);
        checkOutput({tag, "_ill"},   32'(illegal),        32'd0);
`ifdef SIMD_FD_PERF_COUNT_EN
        checkOutput({tag, "_cnt"},   32'(issue_count),    32'd0);
`endif
    endtask

    initial begin
        int  n;
        bit  stableOk;

        // Reset state
        rstn = 1'b0;
        applyStimulus(1'b0, 1'b0);
        loadProgramA();
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Straight program with downstream always ready
        opLog.delete();
        addrLog.delete();
        applyStimulus(1'b0, 1'b1);
        pulseValid();
        checkOutput("lat_busy", 32'(busy), 32'd1);
        checkOutput("lat_addr", 32'(inst_read_addr), 32'd0);
        checkOutput("lat_ivld_early", 32'(issue_valid), 32'd0);
        waitIssue(10, n);
        checkOutput("lat_cycles", 32'(n), 32'd2);
        checkOutput("lat_op", 32'(issue_op), 32'd1);
        waitDone("prog", 40);
        checkOutput("prog_count", 32'(opLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("prog_op%0d", i), 32'(opLog[i]), 32'(i + 1));
            checkOutput($sformatf("prog_addr%0d", i), 32'(addrLog[i]), 32'd0);
        end
        checkOutput("prog_busy", 32'(busy), 32'd0);
        checkOutput("prog_ivld", 32'(issue_valid), 32'd0);
        checkOutput("prog_ill", 32'(illegal), 32'd0);
`ifdef SIMD_FD_PERF_COUNT_EN
        checkOutput("prog_cnt", 32'(issue_count), 32'd4);
`endif

        // Backpressure on the first issue
        opLog.delete();
        addrLog.delete();
        applyStimulus(1'b0, 1'b0);
        pulseValid();
        checkOutput("bp_stop_clr", 32'(stop), 32'd0);
        waitIssue(10, n);
        checkOutput("bp_cycles", 32'(n), 32'd2);
        stableOk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(issue_valid === 1'b1 && issue_op === 4'h1 &&
                  issue_addr === 8'h00 && inst_read_addr === 12'h000)) stableOk = 1'b0;
        end
        checkOutput("bp_stable", 32'(stableOk), 32'd1);
        checkOutput("bp_no_issue", 32'(opLog.size()), 32'd0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bp_one_issue", 32'(opLog.size()), 32'd1);
        checkOutput("bp_ivld_drop", 32'(issue_valid), 32'd0);
        checkOutput("bp_pc_next", 32'(inst_read_addr), 32'd1);
        waitDone("bp", 40);
        checkOutput("bp_count", 32'(opLog.size()), 32'd4);

        // NOPs are skipped at two cycles each
        fillMem(12'hF00);
        mem[0] = 12'h000;
        mem[1] = 12'h000;
        mem[2] = 12'h1A5;
        mem[3] = 12'h400;
        opLog.delete();
        addrLog.delete();
        applyStimulus(1'b0, 1'b1);
        pulseValid();
        waitIssue(20, n);
        checkOutput("nop_cycles", 32'(n), 32'd6);
        checkOutput("nop_op", 32'(issue_op), 32'd1);
        checkOutput("nop_iaddr", 32'(issue_addr), 32'hA5);
        checkOutput("nop_pc", 32'(inst_read_addr), 32'd2);
        waitDone("nop", 40);
        checkOutput("nop_count", 32'(opLog.size()), 32'd2);
        checkOutput("nop_last_op", 32'(opLog[1]), 32'd4);

        // Illegal opcode ends the program
        fillMem(12'hF00);
        mem[0] = 12'h100;
        mem[1] = 12'h9FF;
        opLog.delete();
        addrLog.delete();
        pulseValid();
        waitDone("ill", 30);
        checkOutput("ill_count", 32'(opLog.size()), 32'd1);
        checkOutput("ill_flag", 32'(illegal), 32'd1);
        checkOutput("ill_busy", 32'(busy), 32'd0);
        checkOutput("ill_op", 32'(issue_op), 32'd9);
        checkOutput("ill_ivld", 32'(issue_valid), 32'd0);

        // valid while busy is ignored; restart after DONE
        loadProgramA();
        opLog.delete();
        addrLog.delete();
        applyStimulus(1'b0, 1'b0);
        pulseValid();
        checkOutput("rs_ill_clr", 32'(illegal), 32'd0);
        checkOutput("rs_stop_clr", 32'(stop), 32'd0);
        valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        checkOutput("rs_ignored_ivld", 32'(issue_valid), 32'd1);
        checkOutput("rs_ignored_pc", 32'(inst_read_addr), 32'd0);
        applyStimulus(1'b0, 1'b1);
        waitDone("rs", 40);
        checkOutput("rs_count", 32'(opLog.size()), 32'd4);
        pulseValid();
        checkOutput("rs2_stop", 32'(stop), 32'd0);
        checkOutput("rs2_pc", 32'(inst_read_addr), 32'd0);
        checkOutput("rs2_busy", 32'(busy), 32'd1);
        waitDone("rs2", 40);

        // pc wraps to 0, then reset lands in the middle of an ISSUE
        fillMem(12'h000);
        mem[0] = 12'h1AB;
        opLog.delete();
        addrLog.delete();
        applyStimulus(1'b0, 1'b1);
        pulseValid();
        waitIssue(10, n);
        checkOutput("wrap_first_op", 32'(issue_op), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("wrap_first_hs", 32'(opLog.size()), 32'd1);
        waitIssue(9000, n);
        checkOutput("wrap_cycles", 32'(n), 32'd8192);
        checkOutput("wrap_pc", 32'(inst_read_addr), 32'd0);
        checkOutput("wrap_iaddr", 32'(issue_addr), 32'hAB);
        rstn = 1'b0;
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkResetState("midrst");
        checkOutput("midrst_no_hs", 32'(opLog.size()), 32'd1);
        rstn = 1'b1;
        applyStimulus(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("post_ivld", 32'(issue_valid), 32'd0);
        checkOutput("post_busy", 32'(busy), 32'd0);
        checkOutput("post_no_hs", 32'(opLog.size()), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/simd_fetch_decode.md
SIMD_FETCH_DECODE -- requirements
Module: simd_fetch_decode

Interface
REQ-001 The module SHALL have parameter INST_LEN, default 12, giving the instruction word width.
REQ-002 The module SHALL have parameter PC_LEN, default 12, giving the program counter and instruction address width.
REQ-003 The module SHALL have parameter DRAM_DEPTH, default 256, with localparam DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH), giving the operand address width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port valid, input, 1 bit: program start request, sampled only in IDLE or DONE.
REQ-007 The module SHALL have port inst_read_addr, output, PC_LEN bits: instruction memory address.
REQ-008 The module SHALL have port inst_read_data, input, INST_LEN bits: instruction memory data, valid one cycle after the address.
REQ-009 The module SHALL have port issue_valid, output, 1 bit: the decoded instruction is offered downstream.
REQ-010 The module SHALL have port issue_ready, input, 1 bit: downstream accepts the offered instruction.
REQ-011 The module SHALL have port issue_op, output, 4 bits: the decoded opcode, inst[INST_LEN-1:INST_LEN-4].
REQ-012 The module SHALL have port issue_addr, output, DRAM_ADDR_WIDTH bits: the operand address, inst[DRAM_ADDR_WIDTH-1:0].
REQ-013 The module SHALL have ports busy, stop and illegal, outputs, 1 bit each: running; program ended; illegal opcode seen.

Function
REQ-014 Opcodes SHALL be NOP=0x0, FETCH_A=0x1, FETCH_B=0x2, ADD=0x3, STOP=0x4, SUB=0x5, MUL=0x6 and STORE=0x7; opcodes 0x8-0xF are illegal.
REQ-015 The FSM SHALL have states IDLE, FETCH, LATCH, ISSUE and DONE.
REQ-016 IDLE/DONE with valid=1 SHALL transition to FETCH, set pc to 0, clear stop and clear illegal.
REQ-017 In FETCH, inst_read_addr SHALL equal pc, and the FSM SHALL go to LATCH next cycle.
REQ-018 In LATCH, inst_read_data SHALL be registered into the issue_op and issue_addr registers, and the FSM SHALL then take the first applicable branch: NOP -> FETCH with pc+1; illegal -> DONE with illegal=1; otherwise -> ISSUE.
REQ-019 In ISSUE, issue_valid SHALL be 1, with issue_op and issue_addr held stable until issue_ready=1.
REQ-020 On an ISSUE handshake: op STOP -> DONE; any other op -> FETCH with pc+1.
REQ-021 The STOP instruction SHALL itself be issued (one handshake) before DONE is entered.
REQ-022 In DONE, stop SHALL be 1 and held until the next valid is accepted.
REQ-023 busy SHALL be 1 in FETCH, LATCH and ISSUE, and 0 in IDLE and DONE.
REQ-024 valid while busy=1 SHALL be ignored.
REQ-025 pc SHALL wrap from 2^PC_LEN-1 to 0 with no flag.
REQ-026 Latency: valid sampled at edge k -> inst_read_addr=0 during cycle k+1 -> issue_valid=1 from cycle k+3; minimum 3 cycles per issued instruction, 2 per NOP.
REQ-027 issue_valid SHALL never be 1 outside ISSUE.

Reset
REQ-028 When rstn=0 at a clock edge, the block SHALL enter IDLE with pc=0, inst_read_addr=0, issue_valid=0, issue_op=0, issue_addr=0, busy=0, stop=0 and illegal=0.
REQ-029 Reset SHALL take priority over valid and issue_ready.
REQ-030 Reset in any state, including mid-ISSUE, SHALL abort the program with no further issue.

Configuration
REQ-031 With macro SIMD_FD_PERF_COUNT_EN defined, the module SHALL add output issue_count, PC_LEN bits, that is cleared by reset and on accepted valid, increments once per ISSUE handshake (STOP included) and saturates at all-ones.
REQ-032 Without SIMD_FD_PERF_COUNT_EN, the issue_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL load program {0x100, 0x200, 0x300, 0x400}, hold issue_ready=1 and pulse valid -> four issues (op 1,2,3,4; addr 0x00), stop=1 after the 4th, busy=0, issue_count=4.
REQ-034 The bench SHALL hold issue_ready=0 for 5 cycles on the first issue -> issue_valid held, op/addr stable, pc not advanced, no duplicate issue.
REQ-035 The bench SHALL run program {0x000, 0x000, 0x1A5, 0x400} -> NOPs not issued; first issue is op 1/addr 0xA5 at cycle k+7.
REQ-036 The bench SHALL run program {0x100, 0x9FF} -> one issue, then illegal=1, stop=1, no second issue_valid.
REQ-037 The bench SHALL pulse valid during FETCH -> ignored; after DONE, a second valid -> restarts at pc=0 with stop cleared.
REQ-038 The bench SHALL drop rstn for 1 cycle while in ISSUE -> all outputs return to reset values next cycle, with no handshake completing.
